// File: rtl/input_ctrl_pkg.sv
// Shared definitions for the input-control path.
//   - Per-channel key FSM state encoding.
//   - Synchronizer depth.
//   - Helper that sizes the repeat counter.
package input_ctrl_pkg;

  localparam int unsigned SYNC_STAGES = 2;

  typedef logic [1:0] chan_state_t;

  localparam chan_state_t IDLE = 2'd0;
  localparam chan_state_t HOLD = 2'd1;
  localparam chan_state_t RPT  = 2'd2;

  // Width able to hold max(a, b) without wrapping.
  function automatic int unsigned cnt_width(int unsigned a, int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_rpt_if.sv
// Button bundle between the input pins / frequency divider and the debouncer.
//   tick_clk    : slow square wave from the divider (treated as data)
//   btn_raw     : raw bouncy buttons, active-high
//   btn_level   : debounced level
//   btn_press   : one-cycle pulse on debounced 0->1
//   btn_release : one-cycle pulse on debounced 1->0
//   btn_repeat  : one-cycle auto-repeat pulse while held
// master drives tick_clk/btn_raw and consumes the events; slave is the debouncer.
interface btn_debounce_rpt_if #(
  parameter int unsigned NBTN = 4
) ();

  logic            tick_clk;
  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] btn_level;
  logic [NBTN-1:0] btn_press;
  logic [NBTN-1:0] btn_release;
  logic [NBTN-1:0] btn_repeat;

  modport master (
    output tick_clk,
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_repeat
  );

  modport slave (
    input  tick_clk,
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_repeat
  );

endinterface

// File: rtl/btn_chan.sv
// One debounce / key-event channel.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   tick_i     : one-clk sample strobe
//   raw_i      : raw asynchronous button
//   level_o    : debounced level
//   press_o    : pulse on debounced 0->1
//   release_o  : pulse on debounced 1->0
//   repeat_o   : auto-repeat pulse while held
module btn_chan
  import input_ctrl_pkg::*;
#(
  parameter int unsigned NSAMP       = 4,
  parameter int unsigned REPEAT_DLY  = 50,
  parameter int unsigned REPEAT_RATE = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int unsigned CntW = cnt_width(REPEAT_DLY, REPEAT_RATE);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [NSAMP-1:0]       shreg_q, shreg_d;
  logic                   eval_q;
  logic                   level_q, level_d;
  chan_state_t            state_q, state_d;
  logic [CntW-1:0]        rcnt_q, rcnt_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   repeat_q, repeat_d;

  logic all_ones, all_zeros;

  assign all_ones  = &shreg_q;
  assign all_zeros = ~|shreg_q;

  always_comb begin
    shreg_d   = shreg_q;
    level_d   = level_q;
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;

    if (tick_i) begin
      shreg_d = {shreg_q[NSAMP-2:0], sync_q[SYNC_STAGES-1]};
    end

    // Level and repeat decisions share the cycle after the shift, so a release
    // landing on a due repeat is resolved here in favour of the release.
    if (eval_q) begin
      if (all_ones && !level_q) begin
        level_d = 1'b1;
        press_d = 1'b1;
        state_d = HOLD;
        rcnt_d  = CntW'(REPEAT_DLY);
      end else if (all_zeros && level_q) begin
        level_d   = 1'b0;
        release_d = 1'b1;
        state_d   = IDLE;
        rcnt_d    = '0;
      end else if (state_q != IDLE) begin
        if (rcnt_q == CntW'(1)) begin
          repeat_d = 1'b1;
          state_d  = RPT;
          rcnt_d   = CntW'(REPEAT_RATE);
        end else if (rcnt_q != '0) begin
          rcnt_d = rcnt_q - CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      shreg_q   <= '0;
      eval_q    <= 1'b0;
      level_q   <= 1'b0;
      state_q   <= IDLE;
      rcnt_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], raw_i};
      shreg_q   <= shreg_d;
      eval_q    <= tick_i;
      level_q   <= level_d;
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/btn_debounce_rpt.sv
// Multi-button debouncer and key-event generator.
// Turns the divider square wave into a one-clk sample strobe and runs NBTN
// independent debounce / auto-repeat channels on it.
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : btn_debounce_rpt_if slave (tick_clk, btn_raw in; level and
//           press/release/repeat pulses out, all registered)
module btn_debounce_rpt
  import input_ctrl_pkg::*;
#(
  parameter int unsigned NBTN        = 4,
  parameter int unsigned NSAMP       = 4,
  parameter int unsigned REPEAT_DLY  = 50,
  parameter int unsigned REPEAT_RATE = 10
) (
  input logic                clk,
  input logic                reset,
  btn_debounce_rpt_if.slave  bus
);

  // Synchronizer plus one extra stage for edge detection. Reset to ones so a
  // tick_clk already high at reset release does not look like a rising edge.
  logic [SYNC_STAGES:0] tsync_q;
  logic                 tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      tsync_q <= '1;
    end else begin
      tsync_q <= {tsync_q[SYNC_STAGES-1:0], bus.tick_clk};
    end
  end

  assign tick = tsync_q[SYNC_STAGES-1] & ~tsync_q[SYNC_STAGES];

  for (genvar i = 0; i < NBTN; i++) begin : g_chan
    btn_chan #(
      .NSAMP      (NSAMP),
      .REPEAT_DLY (REPEAT_DLY),
      .REPEAT_RATE(REPEAT_RATE)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .tick_i   (tick),
      .raw_i    (bus.btn_raw[i]),
      .level_o  (bus.btn_level[i]),
      .press_o  (bus.btn_press[i]),
      .release_o(bus.btn_release[i]),
      .repeat_o (bus.btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce_rpt.sv
module tb_btn_debounce_rpt;

  localparam int NBTN  = 2;
  localparam int NSAMP = 4;
  localparam int DLY   = 5;
  localparam int RATE  = 2;
  localparam int PULSE_K = 14;  // negedge index (within a tick period) of event pulses

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  btn_debounce_rpt_if #(.NBTN(NBTN)) bus ();

  btn_debounce_rpt #(
    .NBTN       (NBTN),
    .NSAMP      (NSAMP),
    .REPEAT_DLY (DLY),
    .REPEAT_RATE(RATE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: counts of consecutive equal samples and press tick index.
  int ones_run[NBTN];
  int zeros_run[NBTN];
  bit m_lvl[NBTN];
  int m_ptick[NBTN];
  int tick_n;
  bit e_prev[NBTN], e_p[NBTN], e_r[NBTN], e_rp[NBTN];

  // Per-tick observation, packed per channel as
  // {lvl before, lvl at pulse slot, lvl at end, press code, release code, repeat code}
  // where code 0 = no pulse, 1 = one pulse at the expected slot, 2 = anything else.
  logic [9*NBTN-1:0] obs_sig, exp_sig;
  logic [NBTN-1:0]   got_p, got_r, got_rp;

  function automatic logic [1:0] code2(int n, bit hit);
    if (n == 0) return 2'd0;
    if (n == 1 && hit) return 2'd1;
    return 2'd2;
  endfunction

  task automatic model_reset();
    tick_n = 0;
    for (int c = 0; c < NBTN; c++) begin
      ones_run[c]  = 0;
      zeros_run[c] = NSAMP;
      m_lvl[c]     = 1'b0;
      m_ptick[c]   = 0;
    end
  endtask

  task automatic model_tick(input logic [NBTN-1:0] raw);
    int d;
    tick_n++;
    for (int c = 0; c < NBTN; c++) begin
      e_prev[c] = m_lvl[c];
      e_p[c] = 1'b0; e_r[c] = 1'b0; e_rp[c] = 1'b0;
      if (raw[c]) begin ones_run[c]++; zeros_run[c] = 0; end
      else begin zeros_run[c]++; ones_run[c] = 0; end
      if (!m_lvl[c] && ones_run[c] >= NSAMP) begin
        m_lvl[c] = 1'b1; e_p[c] = 1'b1; m_ptick[c] = tick_n;
      end else if (m_lvl[c] && zeros_run[c] >= NSAMP) begin
        m_lvl[c] = 1'b0; e_r[c] = 1'b1;
      end else if (m_lvl[c]) begin
        d = tick_n - m_ptick[c];
        if (d >= DLY && (d - DLY) % RATE == 0) e_rp[c] = 1'b1;
      end
    end
  endtask

  task automatic apply_reset(input logic t, input logic [NBTN-1:0] raw);
    @(negedge clk);
    reset = 1'b1;
    bus.tick_clk = t;
    bus.btn_raw = raw;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One tick_clk period: 10 clk low (buttons change here), then 10 clk high.
  task automatic do_tick(input logic [NBTN-1:0] raw);
    int cp[NBTN], cr[NBTN], crp[NBTN];
    bit hp[NBTN], hr[NBTN], hrp[NBTN];
    logic [NBTN-1:0] l13, l14, l19;
    for (int c = 0; c < NBTN; c++) begin
      cp[c] = 0; cr[c] = 0; crp[c] = 0; hp[c] = 0; hr[c] = 0; hrp[c] = 0;
    end
    l13 = '0; l14 = '0; l19 = '0;
    model_tick(raw);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k > 0) begin
        for (int c = 0; c < NBTN; c++) begin
          if (bus.btn_press[c] === 1'b1) begin cp[c]++; if (k == PULSE_K) hp[c] = 1; end
          else if (bus.btn_press[c] !== 1'b0) cp[c] += 2;
          if (bus.btn_release[c] === 1'b1) begin cr[c]++; if (k == PULSE_K) hr[c] = 1; end
          else if (bus.btn_release[c] !== 1'b0) cr[c] += 2;
          if (bus.btn_repeat[c] === 1'b1) begin crp[c]++; if (k == PULSE_K) hrp[c] = 1; end
          else if (bus.btn_repeat[c] !== 1'b0) crp[c] += 2;
        end
        if (k == PULSE_K - 1) l13 = bus.btn_level;
        if (k == PULSE_K) l14 = bus.btn_level;
        if (k == 19) l19 = bus.btn_level;
      end
      if (k == 0) begin bus.tick_clk = 1'b0; bus.btn_raw = raw; end
      if (k == 10) bus.tick_clk = 1'b1;
    end
    for (int c = 0; c < NBTN; c++) begin
      obs_sig[c*9 +: 9] = {l13[c], l14[c], l19[c], code2(cp[c], hp[c]),
                           code2(cr[c], hr[c]), code2(crp[c], hrp[c])};
      exp_sig[c*9 +: 9] = {e_prev[c], m_lvl[c], m_lvl[c], 1'b0, e_p[c], 1'b0, e_r[c],
                           1'b0, e_rp[c]};
      got_p[c]  = (code2(cp[c], hp[c]) == 2'd1);
      got_r[c]  = (code2(cr[c], hr[c]) == 2'd1);
      got_rp[c] = (code2(crp[c], hrp[c]) == 2'd1);
    end
  endtask

  task automatic test_reset();
    logic [4*NBTN-1:0] outs;
    int bad;
    apply_reset(1'b1, 2'b11);
    outs = {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_repeat};
    n_checks++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %h required 0", outs);
    end
    // tick_clk stays high after release: must not produce a strobe
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_repeat} !== '0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_idle: got %0d nonzero cycles required 0", bad);
    end
    // Both buttons held from reset: press on the 4th real tick, on both channels together
    for (int t = 0; t < 4; t++) begin
      do_tick(2'b11);
      n_checks++;
      if (obs_sig !== exp_sig) begin
        n_fail++;
        $display("FAIL reset_first_ticks tick %0d: got %h required %h", tick_n, obs_sig, exp_sig);
      end
    end
    n_checks++;
    if (got_p !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_simul_press: got %b required 11", got_p);
    end
  endtask

  task automatic test_clean_press();
    logic [NBTN-1:0] seq[6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
    int press_at = -1;
    apply_reset(1'b0, 2'b00);
    for (int t = 0; t < 6; t++) begin
      do_tick(seq[t]);
      n_checks++;
      if (obs_sig !== exp_sig) begin
        n_fail++;
        $display("FAIL clean_press tick %0d: got %h required %h", tick_n, obs_sig, exp_sig);
      end
      if (got_p[0]) press_at = tick_n;
    end
    n_checks++;
    if (press_at != 6 || bus.btn_level !== 2'b01) begin
      n_fail++;
      $display("FAIL clean_press_final: got tick %0d level %b required tick 6 level 01",
               press_at, bus.btn_level);
    end
  endtask

  task automatic test_bounce();
    logic [NBTN-1:0] seq[8] = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    int press_at = -1, n_press = 0;
    apply_reset(1'b0, 2'b00);
    for (int t = 0; t < 8; t++) begin
      do_tick(seq[t]);
      n_checks++;
      if (obs_sig !== exp_sig) begin
        n_fail++;
        $display("FAIL bounce tick %0d: got %h required %h", tick_n, obs_sig, exp_sig);
      end
      if (got_p[0]) begin press_at = tick_n; n_press++; end
    end
    n_checks++;
    if (press_at != 6 || n_press != 1) begin
      n_fail++;
      $display("FAIL bounce_press: got tick %0d count %0d required tick 6 count 1",
               press_at, n_press);
    end
  endtask

  task automatic test_auto_repeat();
    int n_hold_rpt = 0, n_late_rpt = 0, rel_at = -1;
    apply_reset(1'b0, 2'b00);
    for (int t = 1; t <= 23; t++) begin
      do_tick((t <= 16) ? 2'b01 : 2'b00);
      n_checks++;
      if (obs_sig !== exp_sig) begin
        n_fail++;
        $display("FAIL auto_repeat tick %0d: got %h required %h", tick_n, obs_sig, exp_sig);
      end
      if (got_rp[0] && t <= 16) n_hold_rpt++;
      if (got_rp[0] && t > 20) n_late_rpt++;
      if (got_r[0]) rel_at = t;
    end
    n_checks++;
    if (n_hold_rpt != 4 || n_late_rpt != 0 || rel_at != 20) begin
      n_fail++;
      $display("FAIL auto_repeat_summary: got %0d/%0d rel %0d required 4/0 rel 20",
               n_hold_rpt, n_late_rpt, rel_at);
    end
  endtask

  task automatic test_collision();
    int n_rpt = 0, rel_at = -1;
    logic rpt_at_rel = 1'b0;
    apply_reset(1'b0, 2'b00);
    // press at tick 4; zeros on ticks 8..11 put the 4th zero on the repeat due at d=7
    for (int t = 1; t <= 13; t++) begin
      do_tick((t <= 7) ? 2'b01 : 2'b00);
      n_checks++;
      if (obs_sig !== exp_sig) begin
        n_fail++;
        $display("FAIL collision tick %0d: got %h required %h", tick_n, obs_sig, exp_sig);
      end
      if (got_rp[0]) n_rpt++;
      if (got_r[0]) begin rel_at = t; rpt_at_rel = bus.btn_repeat[0] | got_rp[0]; end
    end
    n_checks++;
    if (rel_at != 11 || n_rpt != 1 || rpt_at_rel !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_summary: got rel %0d rpts %0d required rel 11 rpts 1",
               rel_at, n_rpt);
    end
  endtask

  task automatic test_reset_mid_hold();
    int bad = 0, press_at = -1;
    apply_reset(1'b0, 2'b00);
    for (int t = 1; t <= 10; t++) begin
      do_tick(2'b10);
      n_checks++;
      if (obs_sig !== exp_sig) begin
        n_fail++;
        $display("FAIL mid_hold tick %0d: got %h required %h", tick_n, obs_sig, exp_sig);
      end
    end
    n_checks++;
    if (bus.btn_level !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_hold_level: got %b required 10", bus.btn_level);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_repeat} !== '0) bad++;
    end
    reset = 1'b0;
    model_reset();
    repeat (15) begin
      @(negedge clk);
      if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_repeat} !== '0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL mid_hold_reset_outputs: got %0d nonzero cycles required 0", bad);
    end
    for (int t = 1; t <= 5; t++) begin
      do_tick(2'b10);
      n_checks++;
      if (obs_sig !== exp_sig) begin
        n_fail++;
        $display("FAIL mid_hold_requal tick %0d: got %h required %h", tick_n, obs_sig, exp_sig);
      end
      if (got_p[1]) press_at = t;
    end
    n_checks++;
    if (press_at != 4) begin
      n_fail++;
      $display("FAIL mid_hold_repress: got tick %0d required 4", press_at);
    end
  endtask

  task automatic test_random();
    logic [NBTN-1:0] raw = '0;
    apply_reset(1'b0, 2'b00);
    for (int t = 0; t < 80; t++) begin
      for (int c = 0; c < NBTN; c++) begin
        if ($urandom_range(0, 9) < 3) raw[c] = ~raw[c];
      end
      do_tick(raw);
      n_checks++;
      if (obs_sig !== exp_sig) begin
        n_fail++;
        $display("FAIL random tick %0d raw %b: got %h required %h", tick_n, raw, obs_sig,
                 exp_sig);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.tick_clk = 1'b1;
    bus.btn_raw = '0;
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_collision();
    test_reset_mid_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_debounce_rpt.md
# btn_debounce_rpt

Multi-button debouncer and key-event generator for the input-control path. It consumes the slow square wave from the frequency divider (`tick_clk`), converts it into a one-`clk` sample strobe, and samples each raw button on that strobe. For every button it outputs a debounced level and single-cycle press, release and auto-repeat pulses for the downstream control FSM. Everything runs in the `clk` domain; `tick_clk` is treated as data, never as a clock.

## Interface

Parameters:
- `NBTN`, 4: number of button channels.
- `NSAMP`, 4: consecutive equal tick samples required to change the debounced level. Range 2–16.
- `REPEAT_DLY`, 50: ticks of continuous hold before the first repeat pulse. Must be ≥1.
- `REPEAT_RATE`, 10: ticks between subsequent repeat pulses. Must be ≥1.

Ports:
- `clk`, in, 1: system clock. All logic is on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `tick_clk`, in, 1: slow square wave from the frequency divider. Asynchronous to `clk` in phase.
- `btn_raw`, in, NBTN: raw, bouncy, asynchronous button inputs. Active-high.
- `btn_level`, out, NBTN: debounced level.
- `btn_press`, out, NBTN: one-cycle pulse on a debounced 0→1 transition.
- `btn_release`, out, NBTN: one-cycle pulse on a debounced 1→0 transition.
- `btn_repeat`, out, NBTN: one-cycle auto-repeat pulse while the button is held.

## Operation

- **Tick strobe**
  - `tick_clk` passes through a 2-flop synchronizer.
  - `tick = s2 & ~s3`, where `s3` is one further delayed copy.
  - Result: one `clk`-wide strobe per `tick_clk` rising edge.
- **Button synchronizers:** each `btn_raw[i]` passes through its own 2-flop synchronizer.
- **Sample shift register:** on each `tick`, per channel, `shreg <= {shreg[NSAMP-2:0], sync_btn}`.
- **Level update:** evaluated in the cycle after the shift.
  - If all ones and `level == 0`: `level <= 1`, pulse `btn_press`.
  - If all zeros and `level == 1`: `level <= 0`, pulse `btn_release`.
  - Otherwise `level` holds.
- **Per-channel FSM**
  - States: `IDLE`, `HOLD`, `RPT`.
  - `IDLE` → `HOLD` on a press. Load `rcnt = REPEAT_DLY`.
  - In `HOLD` or `RPT`, on each `tick`, `rcnt` decrements.
  - When `rcnt == 1` at a tick: pulse `btn_repeat`, reload `rcnt = REPEAT_RATE`, go to (or stay in) `RPT`.
  - From `HOLD` or `RPT`, a release goes to `IDLE` and clears `rcnt`.
- **Counter width:** `rcnt` is `$clog2(max(REPEAT_DLY, REPEAT_RATE) + 1)` bits and never wraps.
- **Simultaneous events**
  - A release and a repeat falling on the same tick: release wins and no repeat pulse is emitted.
  - `btn_press` and `btn_repeat` are never high in the same cycle.
- **Channel independence:** channels are fully independent; simultaneous presses on several buttons produce same-cycle pulses.
- **Reset**
  - Cleared to 0: all synchronizer flops, shift registers, `rcnt`, and every output.
  - FSMs go to `IDLE`.
  - Tick synchronizer flops (`s1`..`s3`) reset to 1, so a `tick_clk` already high at reset release produces no false strobe.
- **Reset mid-press:** no release pulse is emitted. A button still held after reset must re-qualify through `NSAMP` ticks and then produces a fresh press.

## Timing

- Tick strobe: 3 `clk` after a `tick_clk` rising edge.
- Button synchronizer: 2 `clk` latency.
- Debounce latency: the output changes 1 `clk` after the tick strobe on which the NSAMP-th consecutive equal sample is shifted in. Worst case is NSAMP tick periods plus 5 `clk`.
- Press and release: pulses are high in the same cycle the level changes.
- First repeat: REPEAT_DLY ticks after the press tick, then one every REPEAT_RATE ticks.
- Pulse width: every pulse output is exactly one `clk` wide.
- Registering: all outputs are registered; no combinational path from inputs to outputs.

## Structure

- **Shared package `input_ctrl_pkg`:**
  - FSM state encoding: `IDLE=2'd0`, `HOLD=2'd1`, `RPT=2'd2`.
  - Sync depth constant `SYNC_STAGES=2`.
- **Top level:** holds the tick synchronizer and edge detector, and generates `NBTN` channels.
- **Sub-module `btn_chan`:** one channel, containing the synchronizer, shift register, level, FSM, `rcnt`, and the three pulse outputs. Parameters: `NSAMP`, `REPEAT_DLY`, `REPEAT_RATE`.

## Test plan

Bench setup: `NBTN=2`, `NSAMP=4`, `REPEAT_DLY=5`, `REPEAT_RATE=2`, `tick_clk` period 20 `clk`.

1. **Reset:** assert `reset` with `tick_clk=1`, then release → all outputs 0, and no tick strobe until the next `tick_clk` rising edge.
2. **Clean press:** `btn_raw[0]` 0→1 held → `btn_level[0]` rises, with `btn_press[0]` high for one cycle, exactly 1 `clk` after the 4th tick strobe sampling 1. `btn_raw[1]` is untouched and its outputs stay 0.
3. **Bounce:** `btn_raw[0]` toggles 1,0,1 across 3 ticks, then stays 1 → no press until 4 consecutive 1-samples; exactly one press pulse.
4. **Auto-repeat:** hold `btn_raw[0]` for 12 ticks after the press → `btn_repeat[0]` pulses at ticks 5, 7, 9, 11 after the press tick. On release, 4 zero-samples give a single `btn_release[0]` and no further repeats.
5. **Release/repeat collision:** release timed so the 4th zero-sample coincides with a due repeat → `btn_release` pulses and `btn_repeat` stays 0.
6. **Reset mid-hold:** assert `reset` while `btn_level[1]=1` and the FSM is in `RPT` → outputs go 0 with no release pulse. With the button still held, a new `btn_press[1]` follows 4 ticks later.
